// File: rtl/tile_map_writer.sv
// tile_map_writer
//
// Writable COLS x ROWS store of TW-bit tile indices for the map renderer.
// Game logic issues single-cell writes or inclusive rectangular fills. A fill
// is walked row-major by a small FSM at one cell per clock. The pixel renderer
// reads through a one-cycle registered port.
//
// Build option: TILE_FILL_EN
//   defined   - rectangle fill supported (FILL state present)
//   undefined - fill commands are rejected with err, cmd_ready is tied 1,
//               busy is tied 0, cmd_x1/cmd_y1 are unused
//
// Ports:
//   Clk                  system clock, all state on rising edge
//   Reset                asynchronous active-high reset
//   cmd_valid/cmd_ready  command handshake (accept on valid & ready)
//   cmd_op               0 = single write, 1 = rectangle fill
//   cmd_x0/cmd_y0        start cell
//   cmd_x1/cmd_y1        inclusive end cell (fill only)
//   cmd_tile             tile index to write
//   busy                 fill in progress
//   done                 one-cycle pulse, command completed
//   err                  one-cycle pulse, command rejected
//   rd_x/rd_y            read address
//   rd_tile              registered tile at (rd_x, rd_y); all-ones if out of range

module tile_map_writer #(
    parameter int unsigned   COLS       = 28,
    parameter int unsigned   ROWS       = 10,
    parameter int unsigned   TW         = 5,
    parameter logic [TW-1:0] RESET_TILE = 5'd4
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_op,
    input  logic [4:0]    cmd_x0,
    input  logic [3:0]    cmd_y0,
    input  logic [4:0]    cmd_x1,
    input  logic [3:0]    cmd_y1,
    input  logic [TW-1:0] cmd_tile,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic [4:0]    rd_x,
    input  logic [3:0]    rd_y,
    output logic [TW-1:0] rd_tile
);

    logic [TW-1:0] cells [ROWS][COLS];

    logic          accept;
    logic          legal;
    logic          xy0_ok;
    logic          wr_en;
    logic [4:0]    wr_x;
    logic [3:0]    wr_y;
    logic [TW-1:0] wr_tile;
    logic          done_q;
    logic          err_q;

    assign done = done_q;
    assign err  = err_q;

    // Start cell must lie inside the map for every command type.
    assign xy0_ok = (32'(cmd_x0) < COLS) && (32'(cmd_y0) < ROWS);

`ifdef TILE_FILL_EN

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    state_e        state;
    logic          ready_q;
    logic          busy_q;
    logic [4:0]    cx;
    logic [3:0]    cy;
    logic [4:0]    fill_x0;
    logic [4:0]    fill_x1;
    logic [3:0]    fill_y1;
    logic [TW-1:0] fill_tile;
    logic          rect_ok;

    assign rect_ok = (32'(cmd_x1) < COLS) && (32'(cmd_y1) < ROWS) &&
                     (cmd_x1 >= cmd_x0) && (cmd_y1 >= cmd_y0);
    assign legal     = xy0_ok && (!cmd_op || rect_ok);
    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign accept    = cmd_valid && ready_q;

    // The fill cursor owns the write port while filling; otherwise only a
    // legal single write may use it.
    always_comb begin
        wr_en   = 1'b0;
        wr_x    = cmd_x0;
        wr_y    = cmd_y0;
        wr_tile = cmd_tile;
        if (state == StFill) begin
            wr_en   = 1'b1;
            wr_x    = cx;
            wr_y    = cy;
            wr_tile = fill_tile;
        end else if (accept && legal && !cmd_op) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= StIdle;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cx        <= '0;
            cy        <= '0;
            fill_x0   <= '0;
            fill_x1   <= '0;
            fill_y1   <= '0;
            fill_tile <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                StIdle: begin
                    if (accept) begin
                        if (!legal) begin
                            err_q <= 1'b1;
                        end else if (!cmd_op) begin
                            done_q <= 1'b1;
                        end else begin
                            fill_x0   <= cmd_x0;
                            fill_x1   <= cmd_x1;
                            fill_y1   <= cmd_y1;
                            fill_tile <= cmd_tile;
                            cx        <= cmd_x0;
                            cy        <= cmd_y0;
                            state     <= StFill;
                            ready_q   <= 1'b0;
                            busy_q    <= 1'b1;
                        end
                    end
                end
                StFill: begin
                    // The cell at the cursor is written on this same edge.
                    if (cx == fill_x1) begin
                        if (cy == fill_y1) begin
                            state   <= StIdle;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cx <= fill_x0;
                            cy <= cy + 4'd1;
                        end
                    end else begin
                        cx <= cx + 5'd1;
                    end
                end
                default: begin
                    state   <= StIdle;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`else

    // Without fill support any cmd_op=1 is rejected.
    assign legal     = xy0_ok && !cmd_op;
    assign cmd_ready = 1'b1;
    assign busy      = 1'b0;
    assign accept    = cmd_valid;
    assign wr_en     = accept && legal;
    assign wr_x      = cmd_x0;
    assign wr_y      = cmd_y0;
    assign wr_tile   = cmd_tile;

    logic unused_fill_coords;
    assign unused_fill_coords = ^{cmd_x1, cmd_y1};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= accept && legal;
            err_q  <= accept && !legal;
        end
    end

`endif

    // Tile storage; only ever written at in-range addresses.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned y = 0; y < ROWS; y++) begin
                for (int unsigned x = 0; x < COLS; x++) begin
                    cells[y][x] <= RESET_TILE;
                end
            end
        end else if (wr_en) begin
            cells[wr_y][wr_x] <= wr_tile;
        end
    end

    // Registered read: a same-edge write is seen one cycle later.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_tile <= RESET_TILE;
        end else if ((32'(rd_x) < COLS) && (32'(rd_y) < ROWS)) begin
            rd_tile <= cells[rd_y][rd_x];
        end else begin
            rd_tile <= '1;
        end
    end

endmodule

// File: tb/tb_tile_map_writer.sv
// Directed self-checking bench for tile_map_writer. Fill scenarios are
// compiled only when TILE_FILL_EN is defined; otherwise the bench checks that
// fill commands are rejected.

module tb_tile_map_writer;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_op = 1'b0;
    logic [4:0] cmd_x0 = '0;
    logic [3:0] cmd_y0 = '0;
    logic [4:0] cmd_x1 = '0;
    logic [3:0] cmd_y1 = '0;
    logic [4:0] cmd_tile = '0;
    logic       busy;
    logic       done;
    logic       err;
    logic [4:0] rd_x = '0;
    logic [3:0] rd_y = '0;
    logic [4:0] rd_tile;

    int total = 0;
    int bad = 0;

    tile_map_writer dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_x1    (cmd_x1),
        .cmd_y1    (cmd_y1),
        .cmd_tile  (cmd_tile),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .rd_tile   (rd_tile)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One-cycle command pulse; returns at the negedge after the accept edge.
    task automatic issue(input logic op, input logic [4:0] x0, input logic [3:0] y0,
                         input logic [4:0] x1, input logic [3:0] y1, input logic [4:0] tile);
        @(negedge Clk);
        cmd_op = op; cmd_x0 = x0; cmd_y0 = y0; cmd_x1 = x1; cmd_y1 = y1; cmd_tile = tile;
        cmd_valid = 1'b1;
        @(negedge Clk);
        cmd_valid = 1'b0;
    endtask

    task automatic read_cell(input logic [4:0] x, input logic [3:0] y, output logic [4:0] got);
        @(negedge Clk);
        rd_x = x; rd_y = y;
        @(negedge Clk);
        got = rd_tile;
    endtask

    task automatic test_reset;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        total++;
        if ({cmd_ready, busy, done, err} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 1000", {cmd_ready, busy, done, err});
        end
        total++;
        if (rd_tile !== 5'd4) begin
            bad++;
            $display("FAIL reset_rd_tile: got %0d want 4", rd_tile);
        end
    endtask

    task automatic test_single_write;
        @(negedge Clk);
        cmd_op = 1'b0; cmd_x0 = 5'd13; cmd_y0 = 4'd0; cmd_tile = 5'd19;
        cmd_valid = 1'b1;
        rd_x = 5'd13; rd_y = 4'd0;
        @(negedge Clk);
        cmd_valid = 1'b0;
        total++;
        if (rd_tile !== 5'd4) begin
            bad++;
            $display("FAIL raw_old_value: got %0d want 4", rd_tile);
        end
        total++;
        if ({done, err} !== 2'b10) begin
            bad++;
            $display("FAIL single_done: got done/err %b want 10", {done, err});
        end
        @(negedge Clk);
        total++;
        if (rd_tile !== 5'd19) begin
            bad++;
            $display("FAIL raw_new_value: got %0d want 19", rd_tile);
        end
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL single_done_once: got %b want 0", done);
        end
    endtask

    task automatic test_boundary_write;
        logic [4:0] got;
        issue(1'b0, 5'd27, 4'd9, 5'd0, 4'd0, 5'd18);
        total++;
        if ({done, err} !== 2'b10) begin
            bad++;
            $display("FAIL corner_done: got done/err %b want 10", {done, err});
        end
        read_cell(5'd27, 4'd9, got);
        total++;
        if (got !== 5'd18) begin
            bad++;
            $display("FAIL corner_read: got %0d want 18", got);
        end
        read_cell(5'd28, 4'd0, got);
        total++;
        if (got !== 5'd31) begin
            bad++;
            $display("FAIL oob_x_read: got %0d want 31", got);
        end
        read_cell(5'd0, 4'd10, got);
        total++;
        if (got !== 5'd31) begin
            bad++;
            $display("FAIL oob_y_read: got %0d want 31", got);
        end
    endtask

    task automatic test_back_to_back;
        logic [4:0] got;
        @(negedge Clk);
        cmd_op = 1'b0; cmd_x0 = 5'd3; cmd_y0 = 4'd3; cmd_tile = 5'd5;
        cmd_valid = 1'b1;
        @(negedge Clk);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done_first: got %b want 1", done);
        end
        cmd_x0 = 5'd4; cmd_tile = 5'd6;
        @(negedge Clk);
        cmd_valid = 1'b0;
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done_second: got %b want 1", done);
        end
        @(negedge Clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_done_clear: got %b want 0", done);
        end
        read_cell(5'd3, 4'd3, got);
        total++;
        if (got !== 5'd5) begin
            bad++;
            $display("FAIL b2b_cell_a: got %0d want 5", got);
        end
        read_cell(5'd4, 4'd3, got);
        total++;
        if (got !== 5'd6) begin
            bad++;
            $display("FAIL b2b_cell_b: got %0d want 6", got);
        end
    endtask

    task automatic test_illegal;
        logic [4:0] got;
        issue(1'b0, 5'd28, 4'd3, 5'd0, 4'd0, 5'd7);
        total++;
        if ({done, err, cmd_ready, busy} !== 4'b0110) begin
            bad++;
            $display("FAIL illegal_x: got done/err/ready/busy %b want 0110",
                     {done, err, cmd_ready, busy});
        end
        @(negedge Clk);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL illegal_err_once: got %b want 0", err);
        end
        issue(1'b0, 5'd5, 4'd10, 5'd0, 4'd0, 5'd7);
        total++;
        if ({done, err} !== 2'b01) begin
            bad++;
            $display("FAIL illegal_y: got done/err %b want 01", {done, err});
        end
        issue(1'b1, 5'd5, 4'd2, 5'd3, 4'd2, 5'd7);
        total++;
        if ({done, err, cmd_ready, busy} !== 4'b0110) begin
            bad++;
            $display("FAIL illegal_x1_lt_x0: got done/err/ready/busy %b want 0110",
                     {done, err, cmd_ready, busy});
        end
        issue(1'b1, 5'd0, 4'd0, 5'd0, 4'd10, 5'd7);
        total++;
        if ({done, err, cmd_ready, busy} !== 4'b0110) begin
            bad++;
            $display("FAIL illegal_y1_oob: got done/err/ready/busy %b want 0110",
                     {done, err, cmd_ready, busy});
        end
        @(negedge Clk);
        total++;
        if ({err, busy} !== 2'b00) begin
            bad++;
            $display("FAIL illegal_idle_after: got err/busy %b want 00", {err, busy});
        end
        for (int x = 3; x <= 5; x++) begin
            read_cell(5'(x), 4'd2, got);
            total++;
            if (got !== 5'd4) begin
                bad++;
                $display("FAIL illegal_no_write (%0d,2): got %0d want 4", x, got);
            end
        end
        read_cell(5'd0, 4'd0, got);
        total++;
        if (got !== 5'd4) begin
            bad++;
            $display("FAIL illegal_no_write (0,0): got %0d want 4", got);
        end
    endtask

`ifdef TILE_FILL_EN

    task automatic test_fill;
        logic [4:0] got;
        issue(1'b1, 5'd2, 4'd2, 5'd5, 4'd4, 5'd9);
        for (int k = 0; k < 12; k++) begin
            total++;
            if ({busy, cmd_ready, done} !== 3'b100) begin
                bad++;
                $display("FAIL fill_busy cycle %0d: got busy/ready/done %b want 100",
                         k, {busy, cmd_ready, done});
            end
            @(negedge Clk);
        end
        total++;
        if ({busy, cmd_ready, done, err} !== 4'b0110) begin
            bad++;
            $display("FAIL fill_done: got busy/ready/done/err %b want 0110",
                     {busy, cmd_ready, done, err});
        end
        @(negedge Clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL fill_done_once: got %b want 0", done);
        end
        for (int y = 2; y <= 4; y++) begin
            for (int x = 2; x <= 5; x++) begin
                read_cell(5'(x), 4'(y), got);
                total++;
                if (got !== 5'd9) begin
                    bad++;
                    $display("FAIL fill_cell (%0d,%0d): got %0d want 9", x, y, got);
                end
            end
        end
        read_cell(5'd1, 4'd2, got);
        total++;
        if (got !== 5'd4) begin
            bad++;
            $display("FAIL fill_nb (1,2): got %0d want 4", got);
        end
        read_cell(5'd6, 4'd4, got);
        total++;
        if (got !== 5'd4) begin
            bad++;
            $display("FAIL fill_nb (6,4): got %0d want 4", got);
        end
        read_cell(5'd2, 4'd5, got);
        total++;
        if (got !== 5'd4) begin
            bad++;
            $display("FAIL fill_nb (2,5): got %0d want 4", got);
        end
    endtask

    task automatic test_fill_1x1;
        logic [4:0] got;
        issue(1'b1, 5'd7, 4'd7, 5'd7, 4'd7, 5'd2);
        total++;
        if ({busy, cmd_ready} !== 2'b10) begin
            bad++;
            $display("FAIL fill1_busy: got busy/ready %b want 10", {busy, cmd_ready});
        end
        @(negedge Clk);
        total++;
        if ({busy, cmd_ready, done} !== 3'b011) begin
            bad++;
            $display("FAIL fill1_done: got busy/ready/done %b want 011",
                     {busy, cmd_ready, done});
        end
        read_cell(5'd7, 4'd7, got);
        total++;
        if (got !== 5'd2) begin
            bad++;
            $display("FAIL fill1_cell: got %0d want 2", got);
        end
    endtask

    task automatic test_fill_ignore;
        logic [4:0] got;
        issue(1'b1, 5'd0, 4'd0, 5'd1, 4'd0, 5'd3);
        cmd_op = 1'b0; cmd_x0 = 5'd5; cmd_y0 = 4'd5; cmd_tile = 5'd30;
        cmd_valid = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        cmd_valid = 1'b0;
        total++;
        if ({done, err} !== 2'b10) begin
            bad++;
            $display("FAIL ignore_done: got done/err %b want 10", {done, err});
        end
        read_cell(5'd0, 4'd0, got);
        total++;
        if (got !== 5'd3) begin
            bad++;
            $display("FAIL ignore_cell (0,0): got %0d want 3", got);
        end
        read_cell(5'd1, 4'd0, got);
        total++;
        if (got !== 5'd3) begin
            bad++;
            $display("FAIL ignore_cell (1,0): got %0d want 3", got);
        end
        read_cell(5'd2, 4'd0, got);
        total++;
        if (got !== 5'd4) begin
            bad++;
            $display("FAIL ignore_cell (2,0): got %0d want 4", got);
        end
        read_cell(5'd5, 4'd5, got);
        total++;
        if (got !== 5'd4) begin
            bad++;
            $display("FAIL ignore_cell (5,5): got %0d want 4", got);
        end
    endtask

    task automatic test_fill_reset;
        logic [4:0] got;
        issue(1'b1, 5'd0, 4'd9, 5'd27, 4'd9, 5'd15);
        cmd_op = 1'b1; cmd_x0 = 5'd0; cmd_y0 = 4'd0; cmd_x1 = 5'd3; cmd_y1 = 4'd3;
        cmd_tile = 5'd1;
        cmd_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL abort_busy cycle %0d: got %b want 1", k, busy);
            end
            @(negedge Clk);
        end
        #2 Reset = 1'b1;
        cmd_valid = 1'b0;
        #1;
        total++;
        if ({busy, cmd_ready, done, err} !== 4'b0100) begin
            bad++;
            $display("FAIL abort_async: got busy/ready/done/err %b want 0100",
                     {busy, cmd_ready, done, err});
        end
        @(negedge Clk);
        Reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            total++;
            if ({done, err} !== 2'b00) begin
                bad++;
                $display("FAIL abort_no_pulse: got done/err %b want 00", {done, err});
            end
        end
        for (int x = 0; x < 28; x++) begin
            read_cell(5'(x), 4'd9, got);
            total++;
            if (got !== 5'd4) begin
                bad++;
                $display("FAIL abort_row9 (%0d,9): got %0d want 4", x, got);
            end
        end
        read_cell(5'd0, 4'd0, got);
        total++;
        if (got !== 5'd4) begin
            bad++;
            $display("FAIL abort_cell (0,0): got %0d want 4", got);
        end
    endtask

`else

    task automatic test_fill_disabled;
        logic [4:0] got;
        @(negedge Clk);
        cmd_op = 1'b1; cmd_x0 = 5'd1; cmd_y0 = 4'd1; cmd_x1 = 5'd2; cmd_y1 = 4'd2;
        cmd_tile = 5'd7;
        cmd_valid = 1'b1;
        #1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL nofill_ready_pre: got %b want 1", cmd_ready);
        end
        @(negedge Clk);
        cmd_valid = 1'b0;
        total++;
        if ({done, err, cmd_ready, busy} !== 4'b0110) begin
            bad++;
            $display("FAIL nofill_err: got done/err/ready/busy %b want 0110",
                     {done, err, cmd_ready, busy});
        end
        @(negedge Clk);
        total++;
        if ({err, cmd_ready, busy} !== 3'b010) begin
            bad++;
            $display("FAIL nofill_after: got err/ready/busy %b want 010",
                     {err, cmd_ready, busy});
        end
        read_cell(5'd1, 4'd1, got);
        total++;
        if (got !== 5'd4) begin
            bad++;
            $display("FAIL nofill_cell (1,1): got %0d want 4", got);
        end
        read_cell(5'd2, 4'd2, got);
        total++;
        if (got !== 5'd4) begin
            bad++;
            $display("FAIL nofill_cell (2,2): got %0d want 4", got);
        end
    endtask

`endif

    task automatic test_reset_sweep;
        logic [4:0] got;
        // Point the read port at a cell known to hold 19.
        @(negedge Clk);
        rd_x = 5'd13; rd_y = 4'd0;
        @(negedge Clk);
        total++;
        if (rd_tile !== 5'd19) begin
            bad++;
            $display("FAIL sweep_pre: got %0d want 19", rd_tile);
        end
        #2 Reset = 1'b1;
        #1;
        total++;
        if (rd_tile !== 5'd4) begin
            bad++;
            $display("FAIL sweep_async_rd: got %0d want 4", rd_tile);
        end
        @(negedge Clk);
        Reset = 1'b0;
        for (int y = 0; y < 10; y++) begin
            for (int x = 0; x < 28; x++) begin
                rd_x = 5'(x); rd_y = 4'(y);
                @(negedge Clk);
                total++;
                if (rd_tile !== 5'd4) begin
                    bad++;
                    $display("FAIL sweep (%0d,%0d): got %0d want 4", x, y, rd_tile);
                end
            end
        end
        read_cell(5'd28, 4'd0, got);
        total++;
        if (got !== 5'd31) begin
            bad++;
            $display("FAIL sweep_oob: got %0d want 31", got);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_boundary_write();
        test_back_to_back();
        test_illegal();
`ifdef TILE_FILL_EN
        test_fill();
        test_fill_1x1();
        test_fill_ignore();
        test_fill_reset();
        issue(1'b0, 5'd13, 4'd0, 5'd0, 4'd0, 5'd19);
`else
        test_fill_disabled();
`endif
        test_reset_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
